// File: rtl/uart_tx_sched_if.sv
// Requester and transmitter-side signals of the UART TX scheduler.
// master = scheduler, slave = requesters plus transmitter.
interface uart_tx_sched_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic                 active;
  logic [ID_W-1:0]      cur_id;
  logic                 err;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_start, tx_data, active, cur_id, err
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_start, tx_data, active, cur_id, err
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX: frames ID char, payload, LF; registered outputs, ack one cycle after grant.
// Stalls on tx_busy and adds a stop-bit guard gap per byte; UART_TX_SCHED_CKSUM_EN inserts a checksum byte.
module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 4167,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_sched_if.master bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT + 1) : 1;

`ifdef UART_TX_SCHED_CKSUM_EN
  localparam logic [1:0] LAST_IDX = 2'd3;
`else
  localparam logic [1:0] LAST_IDX = 2'd2;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_HI,
    WAIT_LO,
    GAP
  } state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [7:0]         payload_q, payload_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               tx_start_q, tx_start_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               active_q, active_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] req_rot;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [7:0]         gnt_payload;
  logic [7:0]         id_char;
  logic [7:0]         cur_byte;
  logic               byte_done;
  int                 gnt_sum;

  // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    req_rot = NUM_REQ'({bus.req, bus.req} >> rr_ptr_q);
    gnt_vld = 1'b0;
    gnt_id  = '0;
    gnt_sum = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_vld && req_rot[k]) begin
        gnt_vld = 1'b1;
        gnt_sum = int'(rr_ptr_q) + k;
        if (gnt_sum >= NUM_REQ) begin
          gnt_sum = gnt_sum - NUM_REQ;
        end
        gnt_id = ID_W'(gnt_sum);
      end
    end
  end

  always_comb begin
    gnt_payload = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_id == ID_W'(i)) begin
        gnt_payload = bus.req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    id_char = 8'h30 + 8'(cur_id_q);
    case (byte_idx_q)
      2'd0:    cur_byte = id_char;
      2'd1:    cur_byte = payload_q;
`ifdef UART_TX_SCHED_CKSUM_EN
      2'd2:    cur_byte = id_char ^ payload_q;
`endif
      default: cur_byte = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    cur_id_d   = cur_id_q;
    payload_d  = payload_q;
    byte_idx_d = byte_idx_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    ack_d      = '0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    active_d   = active_q;
    err_d      = 1'b0;
    byte_done  = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          ack_d[gnt_id] = 1'b1;
          payload_d     = gnt_payload;
          cur_id_d      = gnt_id;
          active_d      = 1'b1;
          byte_idx_d    = 2'd0;
          if (int'(gnt_id) == NUM_REQ - 1) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = gnt_id + ID_W'(1);
          end
          state_d = SEND;
        end
      end

      SEND: begin
        if (!bus.tx_busy) begin
          tx_data_d  = cur_byte;
          tx_start_d = 1'b1;
          to_cnt_d   = '0;
          state_d    = WAIT_HI;
        end
      end

      // A transmitter that never goes busy drops the packet; rr_ptr has already moved on.
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (to_cnt_q >= TO_W'(BUSY_TIMEOUT - 1)) begin
          err_d    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      WAIT_LO: begin
        if (!bus.tx_busy) begin
          if (GAP_CYCLES == 0) begin
            byte_done = 1'b1;
          end else begin
            gap_cnt_d = GAP_W'(GAP_CYCLES);
            state_d   = GAP;
          end
        end
      end

      GAP: begin
        if (gap_cnt_q <= GAP_W'(1)) begin
          byte_done = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (byte_done) begin
      if (byte_idx_q == LAST_IDX) begin
        active_d = 1'b0;
        state_d  = IDLE;
      end else begin
        byte_idx_d = byte_idx_q + 2'd1;
        state_d    = SEND;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      cur_id_q   <= '0;
      payload_q  <= 8'h00;
      byte_idx_q <= 2'd0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
      ack_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      cur_id_q   <= cur_id_d;
      payload_q  <= payload_d;
      byte_idx_q <= byte_idx_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      ack_q      <= ack_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      active_q   <= active_d;
      err_q      <= err_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.active   = active_q;
  assign bus.cur_id   = cur_id_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed requests, queue scoreboard checked by a negedge monitor
// that also models the UART transmitter's busy flag.
module tb_uart_tx_sched;
  localparam int NREQ    = 4;
  localparam int GAP     = 8;
  localparam int TMO     = 15;
  localparam int BIT_CYC = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy_m = 1'b0;

  always #5 clk = ~clk;

  uart_tx_sched_if #(.NUM_REQ(NREQ)) ifc ();

  assign ifc.tx_busy = busy_m;

  uart_tx_sched #(
    .NUM_REQ      (NREQ),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int tests = 0;
  int fails = 0;
  int exp_bytes[$];
  int exp_ack[$];
  int cyc = 0, ack_seen = 0, start_seen = 0, err_seen = 0;
  int ack_w = 0, st_w = 0, bcnt = 0, start_cyc = 0, fall_cyc = 0;
  int e_id = 0;
  bit gap_vld = 1'b0, model_en = 1'b1, data_vld = 1'b0;
  logic [7:0] start_data = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int id, input int pl);
    exp_ack.push_back(id);
    exp_bytes.push_back(8'h30 + id);
    exp_bytes.push_back(pl);
`ifdef UART_TX_SCHED_CKSUM_EN
    exp_bytes.push_back(((8'h30 + id) ^ pl) & 8'hFF);
`endif
    exp_bytes.push_back(8'h0A);
  endtask

  // Monitor and transmitter model share one process so busy updates and checks never race.
  always @(negedge clk) begin
    cyc++;
    if (rst) data_vld = 1'b0;

    if (ifc.ack != '0) begin
      ack_w++;
      if (ack_w == 1) begin
        check("ack_expected", int'(exp_ack.size() > 0), 1);
        if (exp_ack.size() > 0) begin
          e_id = exp_ack.pop_front();
          check("ack_id", int'(ifc.ack), 1 << e_id);
          check("cur_id", int'(ifc.cur_id), e_id);
        end
        ack_seen++;
      end
    end else if (ack_w != 0) begin
      check("ack_width", ack_w, 1);
      ack_w = 0;
    end

    if (ifc.tx_start) begin
      st_w++;
      if (st_w == 1) begin
        check("byte_expected", int'(exp_bytes.size() > 0), 1);
        if (exp_bytes.size() > 0) check("tx_byte", int'(ifc.tx_data), exp_bytes.pop_front());
        if (gap_vld) begin
          check("gap_min", int'((cyc - fall_cyc) >= GAP), 1);
          gap_vld = 1'b0;
        end
        start_cyc  = cyc;
        start_data = ifc.tx_data;
        data_vld   = 1'b1;
        start_seen++;
        if (model_en) begin
          busy_m = 1'b1;
          bcnt   = BIT_CYC;
        end
      end
    end else begin
      if (st_w != 0) begin
        check("tx_start_width", st_w, 1);
        st_w = 0;
      end
      if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) begin
          busy_m = 1'b0;
          if (data_vld) begin
            check("tx_data_stable", int'(ifc.tx_data), int'(start_data));
            fall_cyc = cyc;
            gap_vld  = 1'b1;
          end
        end
      end
    end

    if (ifc.err) begin
      check("err_delay", cyc - start_cyc, TMO);
      check("err_active", int'(ifc.active), 0);
      err_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    ifc.req = '0;
    @(posedge clk);
    #1;
    check("rst_ack", int'(ifc.ack), 0);
    check("rst_tx_start", int'(ifc.tx_start), 0);
    check("rst_tx_data", int'(ifc.tx_data), 0);
    check("rst_active", int'(ifc.active), 0);
    check("rst_cur_id", int'(ifc.cur_id), 0);
    check("rst_err", int'(ifc.err), 0);
    rst = 1'b0;
  endtask

  function automatic int counter(input int which);
    case (which)
      0:       return ack_seen;
      1:       return start_seen;
      default: return err_seen;
    endcase
  endfunction

  task automatic wait_cnt(input string name, input int which, input int n, input int budget);
    int k = 0;
    while (counter(which) < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check(name, int'(counter(which) >= n), 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (ifc.active && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("wait_idle", int'(ifc.active), 0);
  endtask

  initial begin
    int b;
    int k;
    ifc.req      = '0;
    ifc.req_data = '0;

    // 1: single request from requester 0
    do_reset();
    ifc.req_data = 32'h0000_0041;
    push_pkt(0, 'h41);
    b = ack_seen;
    ifc.req = 4'b0001;
    wait_cnt("t1_ack", 0, b + 1, 50);
    tick(1);
    ifc.req = '0;
    wait_idle(500);
    check("t1_active_after_gap", int'((cyc - fall_cyc) >= GAP), 1);

    // 2: all four held, rotation 0,1,2,3,0
    do_reset();
    ifc.req_data = 32'h4030_2010;
    push_pkt(0, 'h10);
    push_pkt(1, 'h20);
    push_pkt(2, 'h30);
    push_pkt(3, 'h40);
    push_pkt(0, 'h10);
    b = ack_seen;
    ifc.req = 4'b1111;
    wait_cnt("t2_acks", 0, b + 5, 1500);
    tick(1);
    ifc.req = '0;
    wait_idle(500);

    // 4: transmitter never goes busy, packets time out in grant order
    do_reset();
    model_en     = 1'b0;
    ifc.req_data = 32'h0000_2211;
    exp_ack.push_back(0);
    exp_bytes.push_back('h30);
    exp_ack.push_back(1);
    exp_bytes.push_back('h31);
    b = err_seen;
    ifc.req = 4'b0011;
    wait_cnt("t4_acks", 0, ack_seen + 2, 200);
    tick(1);
    ifc.req = '0;
    wait_cnt("t4_errs", 2, b + 2, 100);
    model_en = 1'b1;
    tick(2);

    // 5: reset in the middle of the second byte
    do_reset();
    ifc.req_data = 32'h0000_0055;
    exp_ack.push_back(0);
    exp_bytes.push_back('h30);
    exp_bytes.push_back('h55);
    b = start_seen;
    ifc.req = 4'b0001;
    wait_cnt("t5_ack", 0, ack_seen + 1, 50);
    tick(1);
    ifc.req = '0;
    wait_cnt("t5_starts", 1, b + 2, 300);
    tick(3);
    do_reset();
    k = 0;
    while (busy_m && k < 100) begin
      tick(1);
      k++;
    end
    check("t5_busy_drop", int'(busy_m), 0);
    tick(10);
    ifc.req_data = 32'h0022_1100;
    push_pkt(1, 'h11);
    push_pkt(2, 'h22);
    b = ack_seen;
    ifc.req = 4'b0110;
    wait_cnt("t5_ack1", 0, b + 1, 50);
    tick(1);
    ifc.req = 4'b0100;
    wait_cnt("t5_ack2", 0, b + 2, 500);
    tick(1);
    ifc.req = '0;
    wait_idle(500);

    // 6: one-cycle request while busy is withdrawn
    do_reset();
    ifc.req_data = 32'h0099_0066;
    push_pkt(0, 'h66);
    ifc.req = 4'b0001;
    wait_cnt("t6_ack", 0, ack_seen + 1, 50);
    tick(1);
    ifc.req = '0;
    tick(20);
    ifc.req = 4'b0100;
    tick(1);
    ifc.req = '0;
    wait_idle(500);
    tick(20);

    check("bytes_left", exp_bytes.size(), 0);
    check("acks_left", exp_ack.size(), 0);
    check("err_count", err_seen, 2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
